zoom_replicate_ctrl: RTL
========================

Name: zoom_replicate_ctrl

Overview:
- Sequencer for nearest-neighbour zoom-in by pixel replication.
- Scans the source frame in raster order and reads each pixel from a synchronous source RAM.
- Writes that pixel as an escala x escala block into a destination frame RAM.
- Sits between the host command/status registers and the two frame memories; owns all address generation and handshakes for one zoom job.

Parameters:
- SRC_W, 160, source width in pixels
- SRC_H, 120, source height in pixels
- DST_W, 640, destination width in pixels
- DST_H, 480, destination height in pixels
- SRC_AW, 15, source address width (>= clog2(SRC_W*SRC_H))
- DST_AW, 19, destination address width (>= clog2(DST_W*DST_H))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request, sampled only in IDLE
- abort  in  1  synchronous cancel of the running job
- escala  in  3  zoom factor; latched at accepted start
- busy  out  1  high from accepted start until return to IDLE
- done  out  1  one-cycle pulse at job completion
- err  out  1  high after a rejected start, until the next start
- rd_en  out  1  source RAM read strobe
- rd_addr  out  SRC_AW  source address = sy*SRC_W + sx
- rd_data  in  8  source pixel, valid the cycle after rd_en
- wr_en  out  1  destination write request
- wr_addr  out  DST_AW  destination address
- wr_data  out  8  pixel to write
- wr_ready  in  1  destination accepts the write when wr_en && wr_ready

Behaviour:
- Reset (rst_n low, any time including mid-job):
  - state=IDLE; all counters 0.
  - busy, done, err, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data = 0.
- Escala validity: valid iff escala != 0, SRC_W*escala <= DST_W and SRC_H*escala <= DST_H.
- start in IDLE, escala invalid:
  - err=1 from the next cycle; no memory access; stay IDLE.
- start in IDLE, escala valid:
  - latch escala into esc; clear err; sx=sy=ox=oy=0; busy=1; go to READ.
- start while busy: ignored.
- States (Moore outputs):
  - IDLE: wait for start.
  - READ: rd_en=1 for exactly one cycle with rd_addr; go to WAIT.
  - WAIT: capture rd_data into the hold register at the end of this cycle; go to WRITE.
  - WRITE:
    - wr_en=1, wr_data=hold, wr_addr=(sy*esc+oy)*DST_W + sx*esc + ox.
    - Nothing advances while wr_ready=0; outputs stay stable, with no skipped or duplicated writes.
    - On accept, ox increments; when ox wraps from esc-1 to 0, oy increments.
    - On accept with ox=oy=esc-1:
      - if sx=SRC_W-1 and sy=SRC_H-1, go to DONE;
      - else advance sx (wrapping to 0 and incrementing sy) and go to READ.
  - DONE: done=1 for one cycle, busy=0 in the same cycle; go to IDLE.
- Order: blocks are written row-major (oy outer, ox inner); source pixels are visited raster order.
- Throughput: 2 + esc^2 cycles per source pixel with wr_ready=1. Total job time = SRC_W*SRC_H*(2+esc^2) cycles + 1 DONE cycle.
- abort: in any non-IDLE state, go to IDLE next cycle.
  - busy=0; no done; no write completes on that edge.
  - abort has priority over a simultaneous wr_ready accept.
- Address arithmetic:
  - Incremental accumulators (row base += DST_W per oy/sy step; column base += esc per sx step); no general multipliers.
  - All sums computed at DST_AW width; wrap-free by the validity check.
- Destination region outside SRC*esc is never written.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - legal escala range bounds;
  - the 8-bit pixel width constant, shared with the replication datapath.
- One natural sub-module, zoom_addr_gen: owns the sx/sy/ox/oy counters and the incremental rd_addr/wr_addr accumulators, with step/last flags back to the FSM.

Test Plan (bench params SRC_W=4, SRC_H=2, DST_W=16, DST_H=8; source RAM holds addr value as pixel):
- escala=2, wr_ready=1 -> pixel 0x01 (sx=1,sy=0) written to addrs 2,3,18,19 in that order. 32 writes total. done pulses once at cycle 1+8*6+1 after start. busy falls with done.
- escala=1 -> 8 writes, addr = sy*16+sx, data = sy*4+sx. No addr >= 20 touched.
- escala=4 -> last pixel 0x07 fills addrs 76..79, 92..95, 108..111, 124..127. done on the cycle after the write to 127 is accepted.
- escala=2, wr_ready held low 3 cycles during the write to addr 18 -> wr_addr=18 and wr_data=0x01 held stable. Next write is 19; exactly 32 accepts occur.
- escala=0, then escala=5 (20>16) -> err=1, busy=0, rd_en/wr_en never asserted. A later start with escala=2 clears err and runs normally.
- abort asserted during WRITE together with wr_ready=1 -> that write is not counted; IDLE next cycle; no done. rst_n pulsed low mid-job -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/zoom_replicate_ctrl_pkg.sv
// Shared definitions for the pixel-replication zoom sequencer: FSM encoding,
// legal zoom bounds and the pixel width used by the replication datapath.
package zoom_replicate_ctrl_pkg;

  localparam int PIX_W   = 8;
  localparam int ESC_W   = 3;
  localparam int ESC_MIN = 1;
  localparam int ESC_MAX = (1 << ESC_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Largest zoom factor whose replicated image still fits the destination.
  function automatic int max_escala(input int src_w, input int src_h,
                                    input int dst_w, input int dst_h);
    int m;
    m = dst_w / src_w;
    if ((dst_h / src_h) < m) m = dst_h / src_h;
    if (m > ESC_MAX) m = ESC_MAX;
    return m;
  endfunction

endpackage

// File: rtl/zoom_replicate_ctrl_if.sv
// Host command/status and frame-memory signals of one zoom sequencer.
interface zoom_replicate_ctrl_if #(
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19
);
  import zoom_replicate_ctrl_pkg::*;

  logic                 start;
  logic                 abort;
  logic [ESC_W-1:0]     escala;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 rd_en;
  logic [SRC_AW-1:0]    rd_addr;
  logic [PIX_W-1:0]     rd_data;
  logic                 wr_en;
  logic [DST_AW-1:0]    wr_addr;
  logic [PIX_W-1:0]     wr_data;
  logic                 wr_ready;

  // Destination write: a transfer happens on a rising edge where wr_en and
  // wr_ready are both high; while wr_ready is low, wr_en/wr_addr/wr_data hold.
  // Source read: rd_data is valid the cycle after rd_en.
  modport master (
    input  start, abort, escala, rd_data, wr_ready,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort, escala, rd_data, wr_ready,
    input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/zoom_replicate_ctrl_addr_gen.sv
// Source/destination address generation for pixel replication: raster
// counters plus incremental accumulators, no multipliers.
module zoom_addr_gen
  import zoom_replicate_ctrl_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int DST_W  = 640,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [ESC_W-1:0]  esc_in,
  input  logic              step,
  output logic [SRC_AW-1:0] rd_addr,
  output logic [DST_AW-1:0] wr_addr,
  output logic              blk_last,
  output logic              frame_last
);

  localparam int SX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int SY_W = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam logic [DST_AW-1:0] DST_STEP = DST_AW'(DST_W);

  logic [ESC_W-1:0]  esc;
  logic [ESC_W-1:0]  ox;
  logic [ESC_W-1:0]  oy;
  logic [SX_W-1:0]   sx;
  logic [SY_W-1:0]   sy;
  logic [SRC_AW-1:0] rd_acc;
  logic [DST_AW-1:0] row_base;  // sy*esc*DST_W
  logic [DST_AW-1:0] col_base;  // sx*esc
  logic [DST_AW-1:0] oy_off;    // oy*DST_W
  logic              ox_last;
  logic              oy_last;
  logic              sx_last;
  logic              sy_last;

  assign ox_last    = (ox == esc - ESC_W'(1));
  assign oy_last    = (oy == esc - ESC_W'(1));
  assign sx_last    = (sx == SX_W'(SRC_W - 1));
  assign sy_last    = (sy == SY_W'(SRC_H - 1));
  assign blk_last   = ox_last && oy_last;
  assign frame_last = sx_last && sy_last;

  assign rd_addr = rd_acc;
  assign wr_addr = row_base + oy_off + col_base + DST_AW'(ox);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      esc      <= '0;
      ox       <= '0;
      oy       <= '0;
      sx       <= '0;
      sy       <= '0;
      rd_acc   <= '0;
      row_base <= '0;
      col_base <= '0;
      oy_off   <= '0;
    end else if (clear) begin
      esc      <= esc_in;
      ox       <= '0;
      oy       <= '0;
      sx       <= '0;
      sy       <= '0;
      rd_acc   <= '0;
      row_base <= '0;
      col_base <= '0;
      oy_off   <= '0;
    end else if (step) begin
      if (!ox_last) begin
        ox <= ox + ESC_W'(1);
      end else begin
        ox <= '0;
        if (!oy_last) begin
          oy     <= oy + ESC_W'(1);
          oy_off <= oy_off + DST_STEP;
        end else begin
          // Block finished: move to the next source pixel in raster order.
          oy     <= '0;
          oy_off <= '0;
          rd_acc <= rd_acc + SRC_AW'(1);
          if (!sx_last) begin
            sx       <= sx + SX_W'(1);
            col_base <= col_base + DST_AW'(esc);
          end else begin
            sx       <= '0;
            col_base <= '0;
            sy       <= sy_last ? '0 : sy + SY_W'(1);
            // oy_off equals (esc-1)*DST_W here, so this adds esc*DST_W.
            row_base <= row_base + oy_off + DST_STEP;
          end
        end
      end
    end
  end

endmodule

// File: rtl/zoom_replicate_ctrl.sv
// Nearest-neighbour zoom sequencer: reads each source pixel once and writes
// it as an esc x esc block into the destination frame.
module zoom_replicate_ctrl
  import zoom_replicate_ctrl_pkg::*;
#(
  parameter int SRC_W  = 160,
  parameter int SRC_H  = 120,
  parameter int DST_W  = 640,
  parameter int DST_H  = 480,
  parameter int SRC_AW = 15,
  parameter int DST_AW = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  zoom_replicate_ctrl_if.master bus,
  output state_t                state_dbg
);

  localparam int MAX_ESC = max_escala(SRC_W, SRC_H, DST_W, DST_H);

  state_t            state;
  state_t            state_n;
  logic              err_q;
  logic              err_n;
  logic              clear;
  logic              esc_ok;
  logic              accept;
  logic              blk_last;
  logic              frame_last;
  logic [PIX_W-1:0]  hold;
  logic [SRC_AW-1:0] rd_addr_g;
  logic [DST_AW-1:0] wr_addr_g;

  assign esc_ok = (int'(bus.escala) >= ESC_MIN) && (int'(bus.escala) <= MAX_ESC);
  // abort wins over a simultaneous accept, so no write completes on that edge.
  assign accept = (state == ST_WRITE) && bus.wr_ready && !bus.abort;

  zoom_addr_gen #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .DST_W (DST_W),
    .SRC_AW(SRC_AW),
    .DST_AW(DST_AW)
  ) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .esc_in    (bus.escala),
    .step      (accept),
    .rd_addr   (rd_addr_g),
    .wr_addr   (wr_addr_g),
    .blk_last  (blk_last),
    .frame_last(frame_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
      hold  <= '0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      if (state == ST_WAIT) hold <= bus.rd_data;
    end
  end

  always_comb begin
    state_n = state;
    err_n   = err_q;
    clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (esc_ok) begin
            clear   = 1'b1;
            err_n   = 1'b0;
            state_n = ST_READ;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_READ:  state_n = ST_WAIT;
      ST_WAIT:  state_n = ST_WRITE;
      ST_WRITE: begin
        if (accept && blk_last) state_n = frame_last ? ST_DONE : ST_READ;
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    if (bus.abort && (state != ST_IDLE)) state_n = ST_IDLE;
  end

  // Address/data buses read as zero outside their strobe cycles.
  assign bus.rd_en   = (state == ST_READ);
  assign bus.rd_addr = (state == ST_READ) ? rd_addr_g : '0;
  assign bus.wr_en   = (state == ST_WRITE);
  assign bus.wr_addr = (state == ST_WRITE) ? wr_addr_g : '0;
  assign bus.wr_data = (state == ST_WRITE) ? hold : '0;
  assign bus.busy    = (state == ST_READ) || (state == ST_WAIT) || (state == ST_WRITE);
  assign bus.done    = (state == ST_DONE);
  assign bus.err     = err_q;
  assign state_dbg   = state;

endmodule
